// File: rtl/pe_pkg.sv
// Shared definitions for the systolic MAC processing element.
// The optional saturation build is selected with the macro PE_SATURATE_EN.
package pe_pkg;

  // Default element configuration of the matrix engine.
  localparam int PE_BIT_WIDTH = 8;
  localparam int PE_LANES     = 4;
  localparam int PE_ACC_WIDTH = 32;

  // Width of one lane product and of the summed lane products.
  localparam int PE_PROD_WIDTH = 2 * PE_BIT_WIDTH;
  localparam int PE_LSUM_WIDTH = 2 * PE_BIT_WIDTH + $clog2(PE_LANES);

  // Upper limits for the generic helpers below.
  localparam int PE_MAX_WORD = 256;
  localparam int PE_MAX_BW   = 32;
  localparam int PE_MAX_ACC  = 64;

  // Width helpers for parameterised instances.
  function automatic int prod_width(input int bw);
    return 2 * bw;
  endfunction

  function automatic int lsum_width(input int bw, input int lanes);
    return 2 * bw + $clog2(lanes);
  endfunction

  // Extract lane 'lane' of a packed operand word (zero-extended).
  function automatic logic [PE_MAX_BW-1:0] lane_slice(input logic [PE_MAX_WORD-1:0] word,
                                                      input int lane, input int bw);
    logic [PE_MAX_WORD-1:0] shifted;
    logic [PE_MAX_BW-1:0]   mask;
    shifted = word >> (lane * bw);
    mask    = '1;
    mask    = mask >> (PE_MAX_BW - bw);
    return shifted[PE_MAX_BW-1:0] & mask;
  endfunction

  // Saturation bounds of a w-bit accumulator, two's-complement encoded in 64 bits.
  function automatic logic [PE_MAX_ACC-1:0] sat_max(input int w, input bit is_signed);
    logic [PE_MAX_ACC-1:0] one;
    one = 64'd1;
    return is_signed ? ((one << (w - 1)) - one) : ((one << w) - one);
  endfunction

  function automatic logic [PE_MAX_ACC-1:0] sat_min(input int w, input bit is_signed);
    logic [PE_MAX_ACC-1:0] one;
    one = 64'd1;
    return is_signed ? ~((one << (w - 1)) - one) : '0;
  endfunction

endpackage

// File: rtl/pe_lane_dot.sv
// Combinational LANES-wide multiply and adder tree feeding the S1 register.
module pe_lane_dot import pe_pkg::*; #(
  parameter int BIT_WIDTH = PE_BIT_WIDTH,
  parameter int LANES     = PE_LANES,
  parameter int SIGNED    = 1,
  parameter int SUM_WIDTH = lsum_width(PE_BIT_WIDTH, PE_LANES)
) (
  input  logic [LANES*BIT_WIDTH-1:0] a,
  input  logic [LANES*BIT_WIDTH-1:0] b,
  output logic [SUM_WIDTH-1:0]       sum
);

  localparam int PROD_W = prod_width(BIT_WIDTH);

  logic [BIT_WIDTH-1:0] a_i;
  logic [BIT_WIDTH-1:0] b_i;
  logic [PROD_W-1:0]    prod;

  // Sum of per-lane products, each extended per operand signedness.
  always_comb begin
    sum  = '0;
    a_i  = '0;
    b_i  = '0;
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      a_i = BIT_WIDTH'(lane_slice(PE_MAX_WORD'(a), i, BIT_WIDTH));
      b_i = BIT_WIDTH'(lane_slice(PE_MAX_WORD'(b), i, BIT_WIDTH));
      if (SIGNED != 0) begin
        prod = PROD_W'($signed(a_i)) * PROD_W'($signed(b_i));
        sum  = sum + SUM_WIDTH'($signed(prod));
      end else begin
        prod = PROD_W'(a_i) * PROD_W'(b_i);
        sum  = sum + SUM_WIDTH'(prod);
      end
    end
  end

endmodule

// File: rtl/pe_mac_lanes.sv
// Systolic MAC processing element: forwards operands with valid flags, computes
// a LANES-wide dot product per beat, accumulates, and emits on 'last'.
// Define PE_SATURATE_EN for a clamping accumulator; otherwise sums wrap.
// Result port: result_valid rises with a new result and stays high until the
// cycle result_valid & result_ready are both 1; a result arriving while one is
// still held and not being accepted is dropped and err_overflow sets.
module pe_mac_lanes import pe_pkg::*; #(
  parameter int BIT_WIDTH = PE_BIT_WIDTH,
  parameter int ACC_WIDTH = PE_ACC_WIDTH,
  parameter int LANES     = PE_LANES,
  parameter int SIGNED    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [LANES*BIT_WIDTH-1:0] up,
  input  logic                       up_valid,
  input  logic [LANES*BIT_WIDTH-1:0] left,
  input  logic                       left_valid,
  input  logic                       left_last,
  output logic [LANES*BIT_WIDTH-1:0] down,
  output logic                       down_valid,
  output logic [LANES*BIT_WIDTH-1:0] right,
  output logic                       right_valid,
  output logic                       right_last,
  output logic [ACC_WIDTH-1:0]       result,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic                       result_sat,
  output logic                       err_overflow
);

  localparam int LSUM_W = lsum_width(BIT_WIDTH, LANES);

  logic                 fire;
  logic [LSUM_W-1:0]    lane_sum;
  logic [LSUM_W-1:0]    s1_sum;
  logic                 s1_valid;
  logic                 s1_last;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 clamp;
  logic                 sat_acc;
  logic                 s2_go;
  logic                 new_result;

  assign fire       = en & up_valid & left_valid;
  assign s2_go      = en & s1_valid;
  assign new_result = s2_go & s1_last;

  pe_lane_dot #(
    .BIT_WIDTH (BIT_WIDTH),
    .LANES     (LANES),
    .SIGNED    (SIGNED),
    .SUM_WIDTH (LSUM_W)
  ) u_dot (
    .a   (up),
    .b   (left),
    .sum (lane_sum)
  );

`ifdef PE_SATURATE_EN
  // One extra bit above the wider operand so a clamp decision never wraps.
  localparam int XW = ((ACC_WIDTH > LSUM_W) ? ACC_WIDTH : LSUM_W) + 1;

  logic [XW-1:0] acc_x;
  logic [XW-1:0] lsum_x;
  logic [XW-1:0] sum_x;
  logic [XW-1:0] hi_x;
  logic [XW-1:0] lo_x;
  logic          over_hi;
  logic          under_lo;

  // Accumulate at full precision, then clamp to the ACC_WIDTH range.
  always_comb begin
    hi_x = XW'(sat_max(ACC_WIDTH, SIGNED != 0));
    lo_x = XW'(sat_min(ACC_WIDTH, SIGNED != 0));
    if (SIGNED != 0) begin
      acc_x    = XW'($signed(acc));
      lsum_x   = XW'($signed(s1_sum));
      sum_x    = acc_x + lsum_x;
      over_hi  = $signed(sum_x) > $signed(hi_x);
      under_lo = $signed(sum_x) < $signed(lo_x);
    end else begin
      acc_x    = XW'(acc);
      lsum_x   = XW'(s1_sum);
      sum_x    = acc_x + lsum_x;
      over_hi  = sum_x > hi_x;
      under_lo = sum_x < lo_x;
    end
    clamp = over_hi | under_lo;
    if (over_hi)       acc_next = hi_x[ACC_WIDTH-1:0];
    else if (under_lo) acc_next = lo_x[ACC_WIDTH-1:0];
    else               acc_next = sum_x[ACC_WIDTH-1:0];
  end
`else
  logic [ACC_WIDTH-1:0] lsum_acc;

  // Modular accumulate: lane sum extended to ACC_WIDTH, wrap on overflow.
  always_comb begin
    if (SIGNED != 0) lsum_acc = ACC_WIDTH'($signed(s1_sum));
    else             lsum_acc = ACC_WIDTH'(s1_sum);
    acc_next = acc + lsum_acc;
    clamp    = 1'b0;
  end
`endif

  // Operand forwarding, frozen while en is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      down        <= '0;
      down_valid  <= 1'b0;
      right       <= '0;
      right_valid <= 1'b0;
      right_last  <= 1'b0;
    end else if (en) begin
      down        <= up;
      down_valid  <= up_valid;
      right       <= left;
      right_valid <= left_valid;
      right_last  <= left_last;
    end
  end

  // S1: capture the lane sum on fire; a non-firing enabled cycle empties S1.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_sum   <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_valid <= fire;
      if (fire) begin
        s1_sum  <= lane_sum;
        s1_last <= left_last;
      end
    end
  end

  // S2: accumulate, and on 'last' hand the total to the result port.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      sat_acc <= 1'b0;
    end else if (s2_go) begin
      if (s1_last) begin
        acc     <= '0;
        sat_acc <= 1'b0;
      end else begin
        acc     <= acc_next;
        sat_acc <= sat_acc | clamp;
      end
    end
  end

  // Result holding register with valid/ready handshake and drop detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      result       <= '0;
      result_valid <= 1'b0;
      result_sat   <= 1'b0;
      err_overflow <= 1'b0;
    end else if (new_result) begin
      if (!result_valid || result_ready) begin
        result       <= acc_next;
        result_valid <= 1'b1;
        result_sat   <= sat_acc | clamp;
      end else begin
        err_overflow <= 1'b1;
      end
    end else if (result_valid && result_ready) begin
      result_valid <= 1'b0;
    end
  end

endmodule
